// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the cache refill / write-through memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_BUSY = 1'b1
   } rd_state_t;

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_BUSY = 1'b1
   } wr_state_t;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   // Number of byte-offset bits inside one cache line
   function automatic int line_ofs_bits(input int line_width);
      return $clog2(line_width / 8);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_priority_sel.sv
// Read requester selector: fixed lowest-index priority or rotating priority from ptr.
module rr_priority_sel
   import mem_arb_pkg::*;
#(
   parameter int  N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          mode,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   int   cand_s;
   logic found_s;

   // Walk every port once from the start point; the first requester found wins
   always_comb begin
      grant   = '0;
      idx     = '0;
      found_s = 1'b0;
      cand_s  = 0;
      for (int i = 0; i < N; i++) begin
         if (mode == ARB_RR) begin
            cand_s = (int'(ptr) + i) % N;
         end else begin
            cand_s = i;
         end
         if (!found_s && req[cand_s]) begin
            grant[cand_s] = 1'b1;
            idx           = IW'(cand_s);
            found_s       = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates line refill reads from several caches onto one memory read channel and
// forwards a single write channel, holding reads that target a line still being written.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int   NUM_RD_PORTS = 2,
   parameter int   ADDR_WIDTH   = 32,
   parameter int   DATA_WIDTH   = 32,
   parameter int   LINE_WIDTH   = 256,
   parameter logic ARB_MODE     = ARB_RR,
   localparam int  STRB_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic [NUM_RD_PORTS-1:0]            i_rd_req,
   input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] i_rd_addr,
   output logic [LINE_WIDTH-1:0]              o_rd_line,
   output logic [NUM_RD_PORTS-1:0]            o_rd_done,
   input  logic                               i_wr_valid,
   input  logic [ADDR_WIDTH-1:0]              i_wr_addr,
   input  logic [DATA_WIDTH-1:0]              i_wr_data,
   input  logic [STRB_WIDTH-1:0]              i_wr_strb,
   output logic                               o_wr_done,
   output logic                               o_mem_read_req,
   output logic [ADDR_WIDTH-1:0]              o_mem_read_address,
   input  logic                               i_mem_read_done,
   input  logic [LINE_WIDTH-1:0]              i_mem_cache_line,
   output logic                               o_mem_write_valid,
   output logic [ADDR_WIDTH-1:0]              o_mem_write_address,
   output logic [DATA_WIDTH-1:0]              o_mem_write_data,
   output logic [STRB_WIDTH-1:0]              o_mem_write_strobe,
   input  logic                               i_mem_write_done
);

   localparam int IW  = $clog2(NUM_RD_PORTS);
   localparam int OFS = line_ofs_bits(LINE_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] OFS_MASK = (ADDR_WIDTH'(1) << OFS) - ADDR_WIDTH'(1);

   rd_state_t                   rd_state_r, rd_state_s;
   logic [NUM_RD_PORTS-1:0]     grant_oh_r;
   logic [ADDR_WIDTH-1:0]       rd_addr_r;
   logic                        issued_r;
   logic [IW-1:0]               rr_ptr_r;
   logic [NUM_RD_PORTS-1:0]     sel_grant_s;
   logic [IW-1:0]               sel_idx_s;
   logic [ADDR_WIDTH-1:0]       sel_addr_s;
   logic                        hazard_s, rd_issue_s, rd_done_s;

   wr_state_t                   wr_state_r, wr_state_s;
   logic [ADDR_WIDTH-1:0]       wr_addr_r;
   logic [DATA_WIDTH-1:0]       wr_data_r;
   logic [STRB_WIDTH-1:0]       wr_strb_r;
   logic                        wr_done_s;

   rr_priority_sel #(.N(NUM_RD_PORTS)) u_sel (
      .req   (i_rd_req),
      .ptr   (rr_ptr_r),
      .mode  (ARB_MODE),
      .grant (sel_grant_s),
      .idx   (sel_idx_s)
   );

   assign sel_addr_s = i_rd_addr[sel_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
   // Only the registered write state counts, so a write captured alongside a grant bites next cycle
   assign hazard_s   = (wr_state_r == W_BUSY) &&
                       (wr_addr_r[ADDR_WIDTH-1:OFS] == rd_addr_r[ADDR_WIDTH-1:OFS]);

   // Read next-state plus issue/completion decode
   always_comb begin
      rd_state_s = rd_state_r;
      rd_issue_s = 1'b0;
      rd_done_s  = 1'b0;
      case (rd_state_r)
         R_IDLE: begin
            if (|i_rd_req) begin
               rd_state_s = R_BUSY;
            end else begin
               rd_state_s = R_IDLE;
            end
         end
         R_BUSY: begin
            rd_issue_s = issued_r || !hazard_s;
            rd_done_s  = rd_issue_s && i_mem_read_done;
            if (rd_done_s) begin
               rd_state_s = R_IDLE;
            end else begin
               rd_state_s = R_BUSY;
            end
         end
         default: rd_state_s = R_IDLE;
      endcase
   end

   // Read state, grant capture and rotating pointer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_state_r <= R_IDLE;
         grant_oh_r <= '0;
         rd_addr_r  <= '0;
         issued_r   <= 1'b0;
         rr_ptr_r   <= '0;
      end else begin
         rd_state_r <= rd_state_s;
         issued_r   <= rd_issue_s && !rd_done_s;
         if ((rd_state_r == R_IDLE) && (|i_rd_req)) begin
            grant_oh_r <= sel_grant_s;
            rd_addr_r  <= sel_addr_s & ~OFS_MASK;
            if (ARB_MODE == ARB_RR) begin
               rr_ptr_r <= (sel_idx_s == IW'(NUM_RD_PORTS - 1)) ? '0 : sel_idx_s + IW'(1);
            end
         end
      end
   end

   // Completion is steered straight back to the owning requester in the same cycle
   always_comb begin
      if (rd_done_s) begin
         o_rd_done = grant_oh_r;
         o_rd_line = i_mem_cache_line;
      end else begin
         o_rd_done = '0;
         o_rd_line = '0;
      end
   end

   assign o_mem_read_req     = rd_issue_s;
   assign o_mem_read_address = rd_addr_r;

   // Write next-state and completion decode
   always_comb begin
      wr_state_s = wr_state_r;
      wr_done_s  = 1'b0;
      case (wr_state_r)
         W_IDLE: begin
            if (i_wr_valid) begin
               wr_state_s = W_BUSY;
            end else begin
               wr_state_s = W_IDLE;
            end
         end
         W_BUSY: begin
            wr_done_s = i_mem_write_done;
            if (i_mem_write_done) begin
               wr_state_s = W_IDLE;
            end else begin
               wr_state_s = W_BUSY;
            end
         end
         default: wr_state_s = W_IDLE;
      endcase
   end

   // Write holding stage
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_state_r <= W_IDLE;
         wr_addr_r  <= '0;
         wr_data_r  <= '0;
         wr_strb_r  <= '0;
      end else begin
         wr_state_r <= wr_state_s;
         if ((wr_state_r == W_IDLE) && i_wr_valid) begin
            wr_addr_r <= i_wr_addr;
            wr_data_r <= i_wr_data;
            wr_strb_r <= i_wr_strb;
         end
      end
   end

   assign o_wr_done           = wr_done_s;
   assign o_mem_write_valid   = (wr_state_r == W_BUSY);
   assign o_mem_write_address = wr_addr_r;
   assign o_mem_write_data    = wr_data_r;
   assign o_mem_write_strobe  = wr_strb_r;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised successor of the two-port memory translator. Arbitrates cache-line refill reads from `NUM_RD_PORTS` requesters (I-cache, D-cache, future DMA/second core) onto one downstream memory read channel, and forwards one write channel (D-cache write-through) with a registered holding stage. Adds round-robin/fixed-priority selection and a read-after-write line hazard interlock. Sits between the core's caches and `data_mem_top`.

## Interface
- `NUM_RD_PORTS`, 2: number of read requesters (2..8).
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: write data width; `STRB_WIDTH` = `DATA_WIDTH`/8 (derived).
- `LINE_WIDTH`, 256: cache line width in bits; line offset bits `OFS` = log2(`LINE_WIDTH`/8).
- `ARB_MODE`, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `i_rd_req` in `NUM_RD_PORTS`: per-port read request, held until its done.
- `i_rd_addr` in `NUM_RD_PORTS`*`ADDR_WIDTH`: packed per-port addresses, stable while req high.
- `o_rd_line` out `LINE_WIDTH`: returned line, valid only with a done pulse.
- `o_rd_done` out `NUM_RD_PORTS`: one-cycle done, one-hot.
- `i_wr_valid` in 1; `i_wr_addr` in `ADDR_WIDTH`; `i_wr_data` in `DATA_WIDTH`; `i_wr_strb` in `STRB_WIDTH`: upstream write, held until `o_wr_done`.
- `o_wr_done` out 1: one-cycle write completion.
- `o_mem_read_req` out 1; `o_mem_read_address` out `ADDR_WIDTH`; `i_mem_read_done` in 1; `i_mem_cache_line` in `LINE_WIDTH`: downstream read channel.
- `o_mem_write_valid` out 1; `o_mem_write_address` out `ADDR_WIDTH`; `o_mem_write_data` out `DATA_WIDTH`; `o_mem_write_strobe` out `STRB_WIDTH`; `i_mem_write_done` in 1: downstream write channel.

## Operation
- Read FSM: R_IDLE, R_BUSY. In R_IDLE with any `i_rd_req` set: select winner, register grant index and its address (line-aligned: low `OFS` bits zeroed), go R_BUSY.
- Fixed priority: lowest set index. Round-robin: search starts at pointer `rr_ptr`; on grant, `rr_ptr` <= winner+1 mod `NUM_RD_PORTS`.
- R_BUSY: `o_mem_read_req` asserts once hazard-free, then stays high (sticky `issued` flag) until `i_mem_read_done`.
- Hazard: read not issued while write FSM in W_BUSY and `wr_addr[ADDR_WIDTH-1:OFS]` == granted line; issues the cycle after `i_mem_write_done`.
- `i_mem_read_done` in R_BUSY: `o_rd_done[grant]`=1 and `o_rd_line`=`i_mem_cache_line` combinationally that cycle; FSM -> R_IDLE. Requester drops req next cycle; no re-grant race.
- `i_mem_read_done` outside R_BUSY/before issue: ignored.
- Write FSM: W_IDLE, W_BUSY. In W_IDLE with `i_wr_valid`: capture addr/data/strb, -> W_BUSY; `o_mem_write_valid`=1 in W_BUSY. `i_mem_write_done` in W_BUSY: `o_wr_done`=1 combinationally, -> W_IDLE.
- Read and write FSMs run concurrently; a read granted the same edge a write is captured sees the hazard from the next cycle (check uses registered write state, evaluated before issue).

## Timing
- Reset: all outputs 0, both FSMs idle, `rr_ptr`=0, `issued`=0. Reset mid-transaction drops it; downstream memory shares `i_rst_n`.
- Read latency added: 1 cycle (req at cycle 0 -> `o_mem_read_req` cycle 1 if hazard-free); done path 0 cycles.
- Write latency added: 1 cycle; done path 0 cycles.
- Back-to-back: after a done in cycle t, next grant registered at end of t+1, issue at t+2.
- `o_mem_read_address`, `o_mem_write_*` stable for entire request.

## Structure
- Package `mem_arb_pkg`: state enums (R_IDLE/R_BUSY, W_IDLE/W_BUSY), `ARB_FIXED`/`ARB_RR` constants, line-offset helper function.
- One sub-module `rr_priority_sel` (request vector + pointer + mode -> one-hot grant, index); rest in top.

## Test plan
- Single port 0 read addr 0x0000_1234: `o_mem_read_address`=0x0000_1220 cycle 1; memory done cycle 5 with line L -> `o_rd_done`=2'b01, `o_rd_line`=L cycle 5.
- Both ports request every cycle, `ARB_MODE`=1: grants alternate 0,1,0,1 over 4 reads; with `ARB_MODE`=0 port 0 wins all while held.
- Write 0x0000_1040 pending (memory done delayed 6 cycles), read port 1 addr 0x0000_1050: `o_mem_read_req` low until cycle after `i_mem_write_done`; read to 0x0000_2000 instead issues in cycle 1.
- Concurrent write and unrelated read: both downstream valids high together; each done routed only to its requester.
- Assert `i_rst_n`=0 mid R_BUSY and W_BUSY: all outputs 0 immediately; after release, `rr_ptr`=0 and new request granted normally.
- Spurious `i_mem_read_done` in R_IDLE: no `o_rd_done`, state unchanged.
